glm_region_streamer: RTL and testbench

- Source-side counterpart of the GLM operators' FIFO consumers.
- Issues line reads to a local BRAM region and buffers the returned cache lines in an internal FIFO.
- Presents that FIFO to an operator: the operator pops with a registered read-enable and receives data one cycle later.
- Replays the configured region `iterations` times per op; flow control is credit-based, so in-flight reads never overflow the FIFO.

---
 rtl/glm_streamer_pkg.sv | 21 ++
 rtl/glm_stream_fifo.sv | 73 +++++++
 rtl/glm_region_streamer.sv | 173 +++++++++++++++++
 tb/tb_glm_region_streamer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glm_streamer_pkg.sv
// Shared types and constants for the GLM region streamer.
// Optional statistics counters are enabled with GLM_STREAMER_STATS_EN.
package glm_streamer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } t_streamer_state;

   localparam int CFG_BASE_LSB      = 0;
   localparam int CFG_COUNT_LSB     = 16;
   localparam int CFG_FIELD_W       = 16;
   localparam int ALMOSTFULL_MARGIN = 8;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/glm_stream_fifo.sv
// Synchronous BRAM-style FIFO: pop data appears one cycle after an accepted pop.
// Pops on empty are ignored; status flags reflect occupancy after the current update.
module glm_stream_fifo
   import glm_streamer_pkg::*;
#(
   parameter int WIDTH      = 512,
   parameter int LOG2_DEPTH = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [WIDTH-1:0]      push_data,
   input  logic                  pop,
   output logic                  rvalid,
   output logic [WIDTH-1:0]      rdata,
   output logic                  empty,
   output logic                  almostfull,
   output logic [LOG2_DEPTH:0]   count
);

   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam logic [LOG2_DEPTH:0] FULL_LVL = (LOG2_DEPTH+1)'(DEPTH);
   localparam logic [LOG2_DEPTH:0] AF_LVL   = (LOG2_DEPTH+1)'(DEPTH - ALMOSTFULL_MARGIN);
   localparam logic [LOG2_DEPTH:0] ONE      = (LOG2_DEPTH+1)'(1);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [LOG2_DEPTH-1:0] wr_ptr;
   logic [LOG2_DEPTH-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;
   logic [LOG2_DEPTH:0]   count_next;

   assign do_pop  = pop && (count != '0);
   // A full FIFO only accepts a push when a pop frees the slot in the same cycle.
   assign do_push = push && ((count != FULL_LVL) || do_pop);

   always_comb begin
      count_next = count;
      if (do_push && !do_pop)
         count_next = count + ONE;
      else if (do_pop && !do_push)
         count_next = count - ONE;
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         rvalid     <= 1'b0;
         rdata      <= '0;
         empty      <= 1'b1;
         almostfull <= 1'b0;
      end else begin
         rvalid     <= do_pop;
         count      <= count_next;
         empty      <= (count_next == '0);
         almostfull <= (count_next >= AF_LVL);
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            rdata  <= mem[rd_ptr];
         end
      end
   end

endmodule

// File: rtl/glm_region_streamer.sv
// Replays a BRAM line region into a FIFO under credit flow control.
// Build with GLM_STREAMER_STATS_EN to add stall/starvation counters.
module glm_region_streamer
   import glm_streamer_pkg::*;
#(
   parameter int WIDTH        = 512,
   parameter int ADDR_WIDTH   = 16,
   parameter int LOG2_DEPTH   = 6,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  op_start,
   input  logic [31:0]           configreg,
   input  logic [15:0]           iterations,
   output logic                  op_done,
   output logic                  busy,
   output logic                  region_re,
   output logic [ADDR_WIDTH-1:0] region_raddr,
   input  logic                  region_rvalid,
   input  logic [WIDTH-1:0]      region_rdata,
   input  logic                  fifo_re,
   output logic                  fifo_rvalid,
   output logic [WIDTH-1:0]      fifo_rdata,
   output logic                  fifo_empty,
   output logic                  fifo_almostfull,
`ifdef GLM_STREAMER_STATS_EN
   output logic [31:0]           stall_cycles,
   output logic [31:0]           consumer_starve,
`endif
   output t_streamer_state       debug_state
);

   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam logic [LOG2_DEPTH+1:0] DEPTH_X = (LOG2_DEPTH+2)'(DEPTH);
   localparam logic [LOG2_DEPTH:0]   ONE     = (LOG2_DEPTH+1)'(1);

   // Handshake: region_re is a one-cycle request; its line returns on
   // region_rvalid exactly READ_LATENCY cycles later. fifo_re pops when the
   // FIFO is not empty and fifo_rvalid/fifo_rdata follow one cycle later.

   t_streamer_state          state;
   logic [CFG_FIELD_W-1:0]   cfg_base;
   logic [CFG_FIELD_W-1:0]   cfg_count;
   logic [CFG_FIELD_W-1:0]   iter_last;
   logic [CFG_FIELD_W-1:0]   line_cnt;
   logic [CFG_FIELD_W-1:0]   iter_cnt;
   logic [CFG_FIELD_W-1:0]   new_base;
   logic [CFG_FIELD_W-1:0]   new_count;
   logic [LOG2_DEPTH:0]      inflight;
   logic [LOG2_DEPTH:0]      fifo_count;
   logic [READ_LATENCY-1:0]  rd_pipe;
   logic                     credit_ok;
   logic                     issue;
   logic                     accept;

   assign new_base  = configreg[CFG_BASE_LSB  +: CFG_FIELD_W];
   assign new_count = configreg[CFG_COUNT_LSB +: CFG_FIELD_W];

   assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < DEPTH_X;
   assign issue     = (state == STREAM) && credit_ok;
   // Only responses to requests issued since the last reset are pushed.
   assign accept    = region_rvalid && rd_pipe[READ_LATENCY-1];

   assign debug_state = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_pipe  <= '0;
         inflight <= '0;
      end else begin
         rd_pipe <= (rd_pipe << 1) | READ_LATENCY'(region_re);
         if (issue && !accept)
            inflight <= inflight + ONE;
         else if (accept && !issue)
            inflight <= inflight - ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cfg_base     <= '0;
         cfg_count    <= '0;
         iter_last    <= '0;
         line_cnt     <= '0;
         iter_cnt     <= '0;
         op_done      <= 1'b0;
         busy         <= 1'b0;
         region_re    <= 1'b0;
         region_raddr <= '0;
      end else begin
         op_done   <= 1'b0;
         region_re <= 1'b0;
         case (state)
            IDLE: begin
               if (op_start) begin
                  cfg_base  <= new_base;
                  cfg_count <= new_count;
                  iter_last <= (iterations == 16'd0) ? '0 : iterations - 16'd1;
                  line_cnt  <= '0;
                  iter_cnt  <= '0;
                  if (new_count == '0) begin
                     op_done <= 1'b1;
                     busy    <= 1'b0;
                  end else begin
                     busy  <= 1'b1;
                     state <= STREAM;
                  end
               end
            end
            STREAM: begin
               if (issue) begin
                  region_re    <= 1'b1;
                  region_raddr <= ADDR_WIDTH'(cfg_base) + ADDR_WIDTH'(line_cnt);
                  if (line_cnt == cfg_count - 16'd1) begin
                     if (iter_cnt < iter_last) begin
                        line_cnt <= '0;
                        iter_cnt <= iter_cnt + 16'd1;
                     end else begin
                        state <= DRAIN;
                     end
                  end else begin
                     line_cnt <= line_cnt + 16'd1;
                  end
               end
            end
            DRAIN: begin
               if (inflight == '0) begin
                  op_done <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   glm_stream_fifo #(
      .WIDTH      (WIDTH),
      .LOG2_DEPTH (LOG2_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (accept),
      .push_data  (region_rdata),
      .pop        (fifo_re),
      .rvalid     (fifo_rvalid),
      .rdata      (fifo_rdata),
      .empty      (fifo_empty),
      .almostfull (fifo_almostfull),
      .count      (fifo_count)
   );

`ifdef GLM_STREAMER_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles    <= '0;
         consumer_starve <= '0;
      end else if ((state == IDLE) && op_start) begin
         stall_cycles    <= '0;
         consumer_starve <= '0;
      end else begin
         if ((state == STREAM) && !credit_ok)
            stall_cycles <= sat_inc32(stall_cycles);
         if (fifo_re && fifo_empty)
            consumer_starve <= sat_inc32(consumer_starve);
      end
   end
`endif

endmodule

// File: tb/tb_glm_region_streamer.sv
// Directed bench for glm_region_streamer: region responder model, monitor
// with expected address/data queues, and a single checking task.
module tb_glm_region_streamer;
   import glm_streamer_pkg::*;

   logic              clk;
   logic              reset;
   logic              op_start;
   logic [31:0]       configreg;
   logic [15:0]       iterations;
   logic              op_done;
   logic              busy;
   logic              region_re;
   logic [15:0]       region_raddr;
   logic              region_rvalid;
   logic [511:0]      region_rdata;
   logic              fifo_re;
   logic              fifo_rvalid;
   logic [511:0]      fifo_rdata;
   logic              fifo_empty;
   logic              fifo_almostfull;
   t_streamer_state   debug_state;
`ifdef GLM_STREAMER_STATS_EN
   logic [31:0]       stall_cycles;
   logic [31:0]       consumer_starve;
`endif

   glm_region_streamer dut (
      .clk             (clk),
      .reset           (reset),
      .op_start        (op_start),
      .configreg       (configreg),
      .iterations      (iterations),
      .op_done         (op_done),
      .busy            (busy),
      .region_re       (region_re),
      .region_raddr    (region_raddr),
      .region_rvalid   (region_rvalid),
      .region_rdata    (region_rdata),
      .fifo_re         (fifo_re),
      .fifo_rvalid     (fifo_rvalid),
      .fifo_rdata      (fifo_rdata),
      .fifo_empty      (fifo_empty),
      .fifo_almostfull (fifo_almostfull),
`ifdef GLM_STREAMER_STATS_EN
      .stall_cycles    (stall_cycles),
      .consumer_starve (consumer_starve),
`endif
      .debug_state     (debug_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [15:0]  exp_addr_q[$];
   logic [511:0] exp_data_q[$];
   int n_vec   = 0;
   int n_miss  = 0;
   int reads   = 0;
   int pops    = 0;
   int dones   = 0;
   int rv_sent = 0;
   int rv_at_done = 0;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] line_data(input logic [15:0] a);
      logic [511:0] d;
      for (int i = 0; i < 16; i++)
         d[i*32 +: 32] = {~a ^ 16'(i), a};
      return d;
   endfunction

   // ---------------- region responder (fixed 2-cycle latency) ----------------
   initial begin
      logic [1:0]  pv;
      logic [15:0] pa0, pa1;
      pv = '0; pa0 = '0; pa1 = '0;
      region_rvalid = 1'b0;
      region_rdata  = '0;
      forever begin
         @(negedge clk);
         region_rvalid = pv[1];
         region_rdata  = pv[1] ? line_data(pa1) : '0;
         if (pv[1]) rv_sent++;
         pv[1] = pv[0];
         pa1   = pa0;
         pv[0] = region_re;
         pa0   = region_raddr;
      end
   end

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (region_re) begin
               reads++;
               if (exp_addr_q.size() == 0)
                  check("unexp_read", 512'(exp_addr_q.size()), 512'd1);
               else
                  check("raddr", 512'(region_raddr), 512'(exp_addr_q.pop_front()));
            end
            if (fifo_rvalid) begin
               pops++;
               if (exp_data_q.size() == 0)
                  check("unexp_pop", 512'(exp_data_q.size()), 512'd1);
               else
                  check("rdata", fifo_rdata, exp_data_q.pop_front());
            end
            if (op_done) begin
               dones++;
               rv_at_done = rv_sent;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic load_exp(input logic [15:0] base, input logic [15:0] cnt, input logic [15:0] iters);
      int it_eff;
      logic [15:0] a;
      it_eff = (iters == 16'd0) ? 1 : int'(iters);
      for (int it = 0; it < it_eff; it++)
         for (int l = 0; l < int'(cnt); l++) begin
            a = base + 16'(l);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(line_data(a));
         end
   endtask

   task automatic start_op(input logic [15:0] base, input logic [15:0] cnt, input logic [15:0] iters);
      reads = 0; pops = 0; dones = 0; rv_sent = 0; rv_at_done = -1;
      configreg  = {cnt, base};
      iterations = iters;
      op_start   = 1'b1;
      @(negedge clk);
      op_start   = 1'b0;
   endtask

   task automatic finish_op(input string tag, input int n);
      int budget;
      budget = 0;
      while (dones == 0 && budget < 3000) begin
         @(negedge clk);
         budget++;
      end
      check({tag, "_done_seen"}, 512'(dones), 512'd1);
      check({tag, "_pushed_at_done"}, 512'(rv_at_done), 512'(n));
      check({tag, "_busy_clear"}, 512'(busy), 512'd0);
      budget = 0;
      while (exp_data_q.size() != 0 && budget < 500) begin
         @(negedge clk);
         budget++;
      end
      repeat (4) @(negedge clk);
      check({tag, "_reads"}, 512'(reads), 512'(n));
      check({tag, "_pops"}, 512'(pops), 512'(n));
      check({tag, "_done_once"}, 512'(dones), 512'd1);
      check({tag, "_lines_left"}, 512'(exp_data_q.size()), 512'd0);
      check({tag, "_empty"}, 512'(fifo_empty), 512'd1);
   endtask

   task automatic run_op(input logic [15:0] base, input logic [15:0] cnt, input logic [15:0] iters,
                         input string tag, input bit retrigger);
      int n;
      n = int'(cnt) * ((iters == 16'd0) ? 1 : int'(iters));
      load_exp(base, cnt, iters);
      start_op(base, cnt, iters);
      check({tag, "_busy"}, 512'(busy), 512'd1);
      if (retrigger) begin
         // a second start while busy must be ignored
         configreg = 32'h0005_0200;
         op_start  = 1'b1;
         @(negedge clk);
         op_start  = 1'b0;
      end
      finish_op(tag, n);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      n_miss++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin
      int budget;
      reset = 1'b1; op_start = 1'b0; configreg = '0; iterations = '0; fifo_re = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 512'(busy), 512'd0);
      check("rst_op_done", 512'(op_done), 512'd0);
      check("rst_region_re", 512'(region_re), 512'd0);
      check("rst_raddr", 512'(region_raddr), 512'd0);
      check("rst_fifo_empty", 512'(fifo_empty), 512'd1);
      check("rst_fifo_rvalid", 512'(fifo_rvalid), 512'd0);
      check("rst_almostfull", 512'(fifo_almostfull), 512'd0);
      check("rst_state", 512'(debug_state), 512'(IDLE));
      reset = 1'b0;
      @(negedge clk);

      // consumer always popping
      fifo_re = 1'b1;
      run_op(16'h0010, 16'd4, 16'd1, "basic", 1'b0);
      run_op(16'h0000, 16'd3, 16'd3, "replay", 1'b1);
      run_op(16'h0100, 16'd2, 16'd0, "iter0", 1'b0);
      run_op(16'hFFFE, 16'd4, 16'd1, "wrap", 1'b0);

      // disabled ops
      fifo_re = 1'b0;
      start_op(16'h0000, 16'd0, 16'd1);
      check("dis_done_next", 512'(op_done), 512'd1);
      @(negedge clk);
      check("dis_done_pulse", 512'(op_done), 512'd0);
      repeat (5) @(negedge clk);
      check("dis_reads", 512'(reads), 512'd0);
      check("dis_empty", 512'(fifo_empty), 512'd1);
      check("dis_done_once", 512'(dones), 512'd1);
      start_op(16'h0040, 16'd0, 16'd1);
      check("dis0_done_next", 512'(op_done), 512'd1);
      repeat (5) @(negedge clk);
      check("dis0_reads", 512'(reads), 512'd0);
      check("dis0_state", 512'(debug_state), 512'(IDLE));

      // backpressure: consumer idle, 100 lines
      load_exp(16'h2000, 16'd100, 16'd1);
      start_op(16'h2000, 16'd100, 16'd1);
      repeat (120) @(negedge clk);
      check("bp_reads", 512'(reads), 512'd64);
      check("bp_re_low", 512'(region_re), 512'd0);
      check("bp_almostfull", 512'(fifo_almostfull), 512'd1);
      check("bp_busy", 512'(busy), 512'd1);
      check("bp_no_done", 512'(dones), 512'd0);
      check("bp_state", 512'(debug_state), 512'(STREAM));
`ifdef GLM_STREAMER_STATS_EN
      check("bp_stall_cnt", 512'(stall_cycles != 32'd0), 512'd1);
`endif
      fifo_re = 1'b1;
      @(negedge clk);
      fifo_re = 1'b0;
      check("bp_pop_rvalid", 512'(fifo_rvalid), 512'd1);
      @(negedge clk);
      check("bp_pop_single", 512'(fifo_rvalid), 512'd0);
      repeat (5) @(negedge clk);
      check("bp_credit_return", 512'(reads), 512'd65);
      fifo_re = 1'b1;
      finish_op("bp", 100);

      // reset in the middle of an op
      fifo_re = 1'b0;
      load_exp(16'h0300, 16'd20, 16'd1);
      start_op(16'h0300, 16'd20, 16'd1);
      budget = 0;
      while (reads < 5 && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      check("rst_mid_reads", 512'(reads >= 5), 512'd1);
      reset = 1'b1;
      #1;
      check("rst_mid_empty", 512'(fifo_empty), 512'd1);
      check("rst_mid_busy", 512'(busy), 512'd0);
      check("rst_mid_re", 512'(region_re), 512'd0);
      exp_addr_q.delete();
      exp_data_q.delete();
      dones = 0;
      @(negedge clk);
      reset = 1'b0;
      fifo_re = 1'b1;
      repeat (10) @(negedge clk);
      check("rst_mid_no_done", 512'(dones), 512'd0);
      check("rst_mid_stale", 512'(fifo_empty), 512'd1);
      run_op(16'h0400, 16'd2, 16'd1, "post_rst", 1'b0);

      // pops on empty produce nothing
      pops = 0;
      fifo_re = 1'b1;
      repeat (6) @(negedge clk);
      check("empty_pop_rvalid", 512'(pops), 512'd0);
      check("empty_pop_empty", 512'(fifo_empty), 512'd1);
      fifo_re = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
